// File: rtl/enum_swap_pkg.sv
// rtl/enum_swap_pkg.sv - enum/opcode types and per-channel transform helpers for enum_swap_pipe
package enum_swap_pkg;

  typedef enum logic [1:0] {TEST_1 = 2'd0, TEST_2 = 2'd1, TEST_3 = 2'd2, TEST_4 = 2'd3} test_t;
  typedef enum logic [1:0] {OP_HOLD = 2'd0, OP_SWAP = 2'd1, OP_NEXT = 2'd2, OP_PREV = 2'd3} op_t;

  localparam int CNT_W = 16;

  // Flip bit 0; a result outside the legal range leaves the value untouched
  function automatic test_t swap(test_t v, int nvals);
    logic [1:0] r;
    r = v ^ 2'b01;
    if (int'(r) >= nvals) return v;
    return test_t'(r);
  endfunction

  // Apply one opcode; out-of-range inputs are returned unchanged
  function automatic test_t xform(test_t v, op_t op, int nvals);
    int vi;
    vi = int'(v);
    if (vi >= nvals) return v;
    case (op)
      OP_SWAP: return swap(v, nvals);
      OP_NEXT: vi = (vi + 1 >= nvals) ? 0 : vi + 1;
      OP_PREV: vi = (vi == 0) ? nvals - 1 : vi - 1;
      default: ;
    endcase
    return test_t'(vi[1:0]);
  endfunction

endpackage

// File: rtl/enum_swap_stage.sv
// rtl/enum_swap_stage.sv - one valid/ready register slice of the enum_swap_pipe datapath
module enum_swap_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Room exists when empty or when the held beat leaves this cycle, so bubbles collapse
  assign in_ready = !valid_q || out_ready;

  // Load a new beat on accept; data only changes when a beat is taken so a stalled output holds
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  // Slice registers, cleared immediately on reset so no in-flight beat survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/enum_swap_pipe.sv
// rtl/enum_swap_pipe.sv - multi-channel enum transform pipeline; ENUM_SWAP_PARITY_EN adds in_par/out_par
module enum_swap_pipe
  import enum_swap_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int NUM_VALS = 4,
  parameter int STAGES   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*NUM_CH-1:0] in_data,
  input  logic [2*NUM_CH-1:0] in_op,
`ifdef ENUM_SWAP_PARITY_EN
  input  logic [NUM_CH-1:0]   in_par,
  output logic [NUM_CH-1:0]   out_par,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*NUM_CH-1:0] out_data,
  output logic [NUM_CH-1:0]   out_err,
  output logic [CNT_W-1:0]    xform_cnt
);

`ifdef ENUM_SWAP_PARITY_EN
  localparam int PW = 4*NUM_CH;
  logic [NUM_CH-1:0] x_par;
`else
  localparam int PW = 3*NUM_CH;
`endif

  logic [2*NUM_CH-1:0] x_data;
  logic [NUM_CH-1:0]   x_err;
  logic                ch_bad;
  logic [3:0]          n_xf;
  logic [PW-1:0]       pl_in, pl_out;
  logic [CNT_W:0]      cnt_sum;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Per-channel transform at the pipe input; flagged channels pass through and are not counted
  always_comb begin
    x_data = '0;
    x_err  = '0;
    n_xf   = '0;
    ch_bad = 1'b0;
`ifdef ENUM_SWAP_PARITY_EN
    x_par  = '0;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      ch_bad = (int'(in_data[2*c +: 2]) >= NUM_VALS);
`ifdef ENUM_SWAP_PARITY_EN
      if (in_par[c] != ^in_data[2*c +: 2]) ch_bad = 1'b1;
`endif
      x_err[c] = ch_bad;
      if (ch_bad) x_data[2*c +: 2] = in_data[2*c +: 2];
      else        x_data[2*c +: 2] = xform(test_t'(in_data[2*c +: 2]), op_t'(in_op[2*c +: 2]), NUM_VALS);
      if (!ch_bad && op_t'(in_op[2*c +: 2]) != OP_HOLD) n_xf = n_xf + 4'd1;
`ifdef ENUM_SWAP_PARITY_EN
      x_par[c] = ^x_data[2*c +: 2];
`endif
    end
  end

`ifdef ENUM_SWAP_PARITY_EN
  assign pl_in = {x_par, x_err, x_data};
`else
  assign pl_in = {x_err, x_data};
`endif

  // Register slices chained head to tail; ready ripples back from out_ready
  for (genvar s = 0; s < STAGES; s++) begin : g_st
    logic          up_valid, st_ready, st_valid, dn_ready;
    logic [PW-1:0] up_data, st_data;
    if (s == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = pl_in;
    end else begin : g_body
      assign up_valid = g_st[s-1].st_valid;
      assign up_data  = g_st[s-1].st_data;
    end
    if (s == STAGES-1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_next
      assign dn_ready = g_st[s+1].st_ready;
    end
    enum_swap_stage #(.W(PW)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (up_valid),
      .in_ready (st_ready),
      .in_data  (up_data),
      .out_valid(st_valid),
      .out_ready(dn_ready),
      .out_data (st_data)
    );
  end

  assign in_ready  = g_st[0].st_ready;
  assign out_valid = g_st[STAGES-1].st_valid;
  assign pl_out    = g_st[STAGES-1].st_data;
  assign out_data  = pl_out[2*NUM_CH-1:0];
  assign out_err   = pl_out[3*NUM_CH-1:2*NUM_CH];
`ifdef ENUM_SWAP_PARITY_EN
  assign out_par   = pl_out[4*NUM_CH-1:3*NUM_CH];
`endif

  assign cnt_sum = {1'b0, cnt_q} + {{(CNT_W-3){1'b0}}, n_xf};

  // Saturating transform counter, advanced only by accepted beats
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && in_ready) cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign xform_cnt = cnt_q;

endmodule

// File: tb/tb_enum_swap_pipe.sv
// tb/tb_enum_swap_pipe.sv - directed bench for enum_swap_pipe; ENUM_SWAP_PARITY_EN enables the parity case
`timescale 1ns/1ps
module tb_enum_swap_pipe;

  localparam int ST = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_data = '0;
  logic [7:0] in_op = '0;

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [7:0]  out_data_a, out_data_b;
  logic [3:0]  out_err_a, out_err_b;
  logic [15:0] cnt_a, cnt_b;

  int total = 0;
  int bad   = 0;
  logic [15:0] cnt4 = '0;
  logic [15:0] cnt3 = '0;

`ifdef ENUM_SWAP_PARITY_EN
  logic [3:0] par_flip = '0;
  logic [3:0] in_par;
  logic [3:0] out_par_a, out_par_b;

  function automatic logic [3:0] calc_par(logic [7:0] d);
    logic [3:0] p;
    for (int c = 0; c < 4; c++) p[c] = ^d[2*c +: 2];
    return p;
  endfunction

  always_comb in_par = calc_par(in_data) ^ par_flip;
`endif

  enum_swap_pipe #(.NUM_CH(4), .NUM_VALS(4), .STAGES(ST)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_op(in_op),
`ifdef ENUM_SWAP_PARITY_EN
    .in_par(in_par), .out_par(out_par_a),
`endif
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_err(out_err_a), .xform_cnt(cnt_a)
  );

  enum_swap_pipe #(.NUM_CH(4), .NUM_VALS(3), .STAGES(ST)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_op(in_op),
`ifdef ENUM_SWAP_PARITY_EN
    .in_par(in_par), .out_par(out_par_b),
`endif
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_err(out_err_b), .xform_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [7:0] op;
    logic [7:0] e4d;
    logic [3:0] e4e;
    logic [7:0] e3d;
    logic [3:0] e3e;
    int         a4;
    int         a3;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] sat(logic [15:0] c, int a);
    int s;
    s = int'(c) + a;
    return (s > 65535) ? 16'hFFFF : s[15:0];
  endfunction

  // channel values kept in 0..2 so both instances see only in-range codes
  function automatic logic [7:0] beat_val(int k);
    logic [1:0] c0, c1, c2, c3;
    c0 = 2'(k % 3);
    c1 = 2'((k / 3) % 3);
    c2 = 2'((k + 1) % 3);
    c3 = 2'((k + 2) % 3);
    return {c3, c2, c1, c0};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent, recv, first_block, stale;
    vt[0] = '{8'hE4, 8'h55, 8'hB1, 4'h0, 8'hE1, 4'h8, 4, 3};
    vt[1] = '{8'hE2, 8'h9E, 8'h3F, 4'h0, 8'hE8, 4'h8, 4, 3};
    vt[2] = '{8'h1B, 8'h00, 8'h1B, 4'h0, 8'h1B, 4'h1, 0, 0};
    vt[3] = '{8'hE4, 8'hAA, 8'h39, 4'h0, 8'hC9, 4'h8, 4, 3};
    vt[4] = '{8'hE4, 8'hFF, 8'h93, 4'h0, 8'hD2, 4'h8, 4, 3};
    vt[5] = '{8'h55, 8'h1B, 8'h48, 4'h0, 8'h48, 4'h0, 3, 3};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_out_data", out_data_a, 0);
    chk("rst_out_err", out_err_a, 0);
    chk("rst_cnt", cnt_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      in_data  = vt[i].d;
      in_op    = vt[i].op;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_early", i), out_valid_a, 0);
      @(negedge clk);
      cnt4 = sat(cnt4, vt[i].a4);
      cnt3 = sat(cnt3, vt[i].a3);
      chk($sformatf("v%0d_valid", i), out_valid_a, 1);
      chk($sformatf("v%0d_data4", i), out_data_a, vt[i].e4d);
      chk($sformatf("v%0d_err4", i), out_err_a, vt[i].e4e);
      chk($sformatf("v%0d_data3", i), out_data_b, vt[i].e3d);
      chk($sformatf("v%0d_err3", i), out_err_b, vt[i].e3e);
      chk($sformatf("v%0d_cnt4", i), cnt_a, cnt4);
      chk($sformatf("v%0d_cnt3", i), cnt_b, cnt3);
      @(negedge clk);
    end

    // 10 back-to-back beats with the sink stalled for cycles 3..7
    sent = 0;
    recv = 0;
    first_block = 1;
    for (int c = 0; c < 60 && recv < 10; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 7);
      in_valid  = (sent < 10);
      in_data   = beat_val(sent);
      in_op     = 8'h55;
      #1;
      if (out_valid_a) begin
        chk("stream_data", out_data_a, beat_val(recv) ^ 8'h55);
        if (out_ready) recv++;
      end
      if (in_valid && !in_ready_a && first_block == 1) begin
        first_block = 0;
        chk("stall_depth", sent - recv, ST);
      end
      if (in_valid && in_ready_a) begin
        sent++;
        cnt4 = sat(cnt4, 4);
        cnt3 = sat(cnt3, 4);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_recv", recv, 10);
    chk("stream_sent", sent, 10);
    chk("stall_seen", first_block, 0);
    @(negedge clk);
    chk("stream_empty", out_valid_a, 0);
    chk("stream_cnt4", cnt_a, cnt4);
    chk("stream_cnt3", cnt_b, cnt3);

    // drive the counter to FFFE, then past it
    for (int k = 0; k < 20000 && cnt4 != 16'hFFFE; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h00;
      if (16'hFFFE - cnt4 >= 16'd4) begin
        in_op = 8'h55;
        cnt4  = sat(cnt4, 4);
        cnt3  = sat(cnt3, 4);
      end else begin
        in_op = 8'h01;
        cnt4  = sat(cnt4, 1);
        cnt3  = sat(cnt3, 1);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("sat_preload", cnt_a, 16'hFFFE);
    chk("sat_preload3", cnt_b, cnt3);
    for (int k = 0; k < 2; k++) begin
      in_op    = 8'h55;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      cnt3 = sat(cnt3, 4);
      chk($sformatf("sat_hold%0d", k), cnt_a, 16'hFFFF);
      chk($sformatf("sat_hold3_%0d", k), cnt_b, cnt3);
      @(negedge clk);
    end

    // asynchronous reset with two beats in flight
    repeat (3) @(negedge clk);
    in_data  = 8'h1B;
    in_op    = 8'h55;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'h27;
    @(negedge clk);
    in_valid = 1'b0;
    chk("inflight_valid", out_valid_a, 1);
    chk("inflight_block", in_ready_a | out_ready, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid_a, 0);
    chk("arst_in_ready", in_ready_a, 1);
    chk("arst_cnt", cnt_a, 0);
    chk("arst_cnt3", cnt_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid_a || out_valid_b) stale++;
    end
    chk("no_stale_beat", stale, 0);
    chk("post_rst_cnt", cnt_a, 0);

`ifdef ENUM_SWAP_PARITY_EN
    in_data  = 8'hE4;
    in_op    = 8'h55;
    par_flip = 4'b0010;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    par_flip = 4'b0000;
    @(negedge clk);
    chk("par_valid", out_valid_a, 1);
    chk("par_data", out_data_a, 8'hB5);
    chk("par_err", out_err_a, 4'b0010);
    chk("par_out", out_par_a, calc_par(out_data_a));
    chk("par_cnt", cnt_a, 3);
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/enum_swap_pipe.md
Name: enum_swap_pipe

Overview:
Multi-channel, parametrised successor to the single-bit enum swap function block. Each accepted beat carries one enum value and one opcode per channel. The block applies a package-defined transform (hold/swap/next/prev) to every channel and returns the result through a valid/ready pipeline of configurable depth. It sits between packed-enum producers and consumers, and exercises package enum constants and package functions across a registered datapath.

Parameters:
NUM_CH, 4, number of independent channels (1..8)
NUM_VALS, 4, legal enum cardinality per channel (2..4); codes >= NUM_VALS are out of range
STAGES, 2, pipeline register depth (1..4); equals the latency in cycles

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_data  in  2*NUM_CH  packed test_t per channel; ch0 is at LSBs
in_op  in  2*NUM_CH  packed op_t per channel
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
out_data  out  2*NUM_CH  transformed test_t per channel
out_err  out  NUM_CH  per-channel out-of-range flag travelling with the beat
xform_cnt  out  16  count of accepted channel-transforms whose op is not OP_HOLD

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset state: all stage valids=0, in_ready=1, out_valid=0, out_data=TEST_1 on every channel (all zeros), out_err=0, xform_cnt=0.
- Handshake: a beat transfers when valid && ready on that interface. in_ready = !stage0_valid || stage0_advances, a combinational chain back from out_ready. Bubbles collapse, so full throughput is 1 beat/cycle.
- Once out_valid is high, out_data and out_err hold stable until out_ready is high.
- Latency: a beat accepted in cycle N appears on out_valid in cycle N+STAGES when no stalls occur.
- Transform (combinational, at stage 0 input, per channel):
  - OP_HOLD: value unchanged.
  - OP_SWAP: flip bit 0 (TEST_1<->TEST_2, TEST_3<->TEST_4). If the result is >= NUM_VALS, the value is unchanged.
  - OP_NEXT: (v+1) mod NUM_VALS.
  - OP_PREV: (v+NUM_VALS-1) mod NUM_VALS.
- Out-of-range input: if in value >= NUM_VALS, the value passes through unmodified and out_err[ch]=1, regardless of op.
- xform_cnt: on each accepted input beat, add the number of channels with op != OP_HOLD and in-range value. Saturates at 16'hFFFF, never wraps. Updates one cycle after acceptance.
- Stall: when out_ready=0 and all stages are full, in_ready=0 and no beat is accepted or lost.
- Simultaneous accept and emit with a full pipe: both complete in the same cycle, so occupancy is unchanged.
- Reset mid-operation: all in-flight beats are discarded immediately (asynchronous). No partial output. The counter clears.

Optional Feature:
ENUM_SWAP_PARITY_EN:
- Defined: adds output out_par [NUM_CH-1:0], the even parity of each channel's out_data, registered alongside the data. Adds input in_par [NUM_CH-1:0]. An input parity mismatch forces out_err[ch]=1 and passes that channel through unchanged.
- Undefined: neither port exists and no parity logic is built.

Decomposition:
- Package enum_swap_pkg contains:
  - typedef enum logic [1:0] test_t {TEST_1, TEST_2, TEST_3, TEST_4}
  - typedef enum logic [1:0] op_t {OP_HOLD, OP_SWAP, OP_NEXT, OP_PREV}
  - function swap(test_t, int nvals), returns test_t
  - function xform(test_t, op_t, int nvals), returns test_t
  - localparam CNT_W=16
- One sub-module, enum_swap_stage: a single valid/ready register slice carrying data+err (+par). It is instantiated STAGES times via generate.

Test Plan:
- Reset, then NUM_CH=4, NUM_VALS=4, STAGES=2. in_data={TEST_4,TEST_3,TEST_2,TEST_1}, in_op all OP_SWAP, out_ready=1 -> 2 cycles later out_data={TEST_3,TEST_4,TEST_1,TEST_2}, out_err=0, xform_cnt=4.
- NUM_VALS=3: ch0=TEST_3 with OP_NEXT, ch1=TEST_1 with OP_PREV, ch2=TEST_3 with OP_SWAP, ch3=TEST_4 with OP_NEXT -> out ch0=TEST_1, ch1=TEST_3, ch2=TEST_3, ch3=TEST_4, out_err=4'b1000, xform_cnt += 3.
- Back-to-back 10 beats, out_ready held 0 for cycles 3..7 -> in_ready falls after STAGES beats are buffered; all 10 beats emerge in order, none dropped or duplicated.
- Preload xform_cnt near 16'hFFFE via 1-op beats, then send a 4-op beat -> xform_cnt=16'hFFFF and stays there.
- Assert rst_n low mid-stream with 2 beats in flight -> out_valid=0 and in_ready=1 immediately, counter=0, no stale beat after release.
- With ENUM_SWAP_PARITY_EN: send a wrong in_par on ch1 -> out_err[1]=1, ch1 data unchanged, out_par matches out_data.
